uart_rx: RTL and testbench

- Serial receiver, the counterpart of uart_tx: deserializes the 8N1 line driven by uart_tx into parallel bytes.
- Shares the 16x-oversampling tick from baudrate_generator (BAUD_RATE 19200, CLK_FREQ 50 MHz); one tick every 163 clk.
- Samples each bit at its midpoint, reports completed bytes with a one-cycle strobe and flags framing errors.

---
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, 16x oversampled mid-bit sampling,
// one-clk done / framing-error strobes. Define UART_RX_PARITY_EN for an even-parity bit.
module uart_rx #(
    parameter int NB_DATA      = 8,
    parameter int NB_STOP      = 16,
    parameter int OVERSAMPLING = 16
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rxdone,
    output logic               o_frame_err,
    output logic               o_parity_err
);

    localparam int CNT_MAX = (NB_STOP > OVERSAMPLING) ? NB_STOP : OVERSAMPLING;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int BIT_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLING / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(OVERSAMPLING - 1);
    localparam logic [CNT_W-1:0] STOP_CNT = CNT_W'(NB_STOP - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NB_DATA - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   tick_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [NB_DATA-1:0] shreg;
    logic               sync_p0;
    logic               sync_p1;
    logic               rx_s;

    // Synchronizer stage: i_data is asynchronous to clk, resets to the idle level.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= i_data;
            sync_p1 <= sync_p0;
        end
    end

    assign rx_s = sync_p1;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
`else
    assign o_parity_err = 1'b0;
`endif

    // Receive FSM stage: strobes default low and pulse for a single clk.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_rxdone    <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
            par_bad      <= 1'b0;
`endif
        end else begin
            o_rxdone    <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (i_tick) begin
                        if (tick_cnt == MID_CNT) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (tick_cnt == BIT_CNT) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[NB_DATA-1:1]};
                            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (i_tick) begin
                        if (tick_cnt == BIT_CNT) begin
                            tick_cnt <= '0;
                            par_bad  <= (^shreg) ^ rx_s;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (i_tick) begin
                        if (tick_cnt == STOP_CNT) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                                if (par_bad) begin
                                    o_parity_err <= 1'b1;
                                end else begin
                                    o_data   <= shreg;
                                    o_rxdone <= 1'b1;
                                end
`else
                                o_data   <= shreg;
                                o_rxdone <= 1'b1;
`endif
                            end else begin
                                // Framing error wins over any parity error.
                                o_frame_err <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand-driven 8N1 frames on a bench-generated tick
// (one tick every TICK_DIV clk), strobe counters sampled on the falling edge.
module tb_uart_rx;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = 16 * TICK_DIV;

    logic       clk;
    logic       i_rst;
    logic       i_tick;
    logic       i_data;
    logic [7:0] o_data;
    logic       o_rxdone;
    logic       o_frame_err;
    logic       o_parity_err;

    int errors;
    int checks;
    int rx_cnt;
    int ferr_cnt;
    int perr_cnt;
    int overlap_cnt;
    int base_rx;
    int base_ferr;
    int base_perr;

`ifdef UART_RX_PARITY_EN
    logic par_flip;
`endif

    uart_rx #(
        .NB_DATA     (8),
        .NB_STOP     (16),
        .OVERSAMPLING(16)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_tick      (i_tick),
        .i_data      (i_data),
        .o_data      (o_data),
        .o_rxdone    (o_rxdone),
        .o_frame_err (o_frame_err),
        .o_parity_err(o_parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        int tick_div;
        tick_div = 0;
        i_tick   = 1'b0;
        forever begin
            @(negedge clk);
            i_tick   = (tick_div == TICK_DIV - 1);
            tick_div = (tick_div + 1) % TICK_DIV;
        end
    end

    always @(negedge clk) begin
        if (o_rxdone) rx_cnt++;
        if (o_frame_err) ferr_cnt++;
        if (o_parity_err) perr_cnt++;
        if (int'(o_rxdone) + int'(o_frame_err) + int'(o_parity_err) > 1) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        base_rx   = rx_cnt;
        base_ferr = ferr_cnt;
        base_perr = perr_cnt;
    endtask

    // Start bit, data LSB first, optional parity, then the stop level for stop_clk clk.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_clk);
        i_data = 1'b0;
        hold(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            i_data = b[i];
            hold(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        i_data = (^b) ^ par_flip;
        hold(BIT_CLK);
`endif
        i_data = stop_v;
        hold(stop_clk);
        i_data = 1'b1;
    endtask

    initial begin
        logic [7:0] b81;
        errors      = 0;
        checks      = 0;
        rx_cnt      = 0;
        ferr_cnt    = 0;
        perr_cnt    = 0;
        overlap_cnt = 0;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
`endif
        i_rst  = 1'b1;
        i_data = 1'b1;
        hold(4);
        check("rst_data", 32'(o_data), 32'h00);
        check("rst_rxdone", 32'(o_rxdone), 32'h0);
        check("rst_frame_err", 32'(o_frame_err), 32'h0);
        check("rst_parity_err", 32'(o_parity_err), 32'h0);
        i_rst = 1'b0;
        hold(2 * BIT_CLK);

        // Single frame; done must come before the stop bit ends.
        mark();
        send_frame(8'hA5, 1'b1, BIT_CLK);
        check("a5_rxdone_cnt", 32'(rx_cnt - base_rx), 32'd1);
        check("a5_data", 32'(o_data), 32'hA5);
        check("a5_frame_err", 32'(ferr_cnt - base_ferr), 32'd0);
        hold(BIT_CLK);

        // Back-to-back with no idle gap between frames.
        mark();
        send_frame(8'h00, 1'b1, BIT_CLK);
        check("b2b_first_cnt", 32'(rx_cnt - base_rx), 32'd1);
        check("b2b_first_data", 32'(o_data), 32'h00);
        send_frame(8'hFF, 1'b1, BIT_CLK);
        check("b2b_second_cnt", 32'(rx_cnt - base_rx), 32'd2);
        check("b2b_second_data", 32'(o_data), 32'hFF);
        check("b2b_frame_err", 32'(ferr_cnt - base_ferr), 32'd0);
        hold(BIT_CLK);

        // Short low pulse is rejected at the start-bit midpoint.
        mark();
        i_data = 1'b0;
        hold(5 * TICK_DIV);
        i_data = 1'b1;
        hold(2 * BIT_CLK);
        check("glitch_no_strobe", 32'((rx_cnt - base_rx) + (ferr_cnt - base_ferr) + (perr_cnt - base_perr)), 32'd0);
        send_frame(8'h3C, 1'b1, BIT_CLK);
        check("after_glitch_cnt", 32'(rx_cnt - base_rx), 32'd1);
        check("after_glitch_data", 32'(o_data), 32'h3C);
        hold(BIT_CLK);

        // Stop bit low for 12 ticks, enough to cover its midpoint sample.
        mark();
        send_frame(8'h5A, 1'b0, 12 * TICK_DIV);
        hold(2 * BIT_CLK);
        check("ferr_cnt", 32'(ferr_cnt - base_ferr), 32'd1);
        check("ferr_no_rxdone", 32'(rx_cnt - base_rx), 32'd0);
        check("ferr_data_kept", 32'(o_data), 32'h3C);

        // Reset one clk in the middle of data bit 4; the line returns to idle with it.
        mark();
        b81    = 8'h81;
        i_data = 1'b0;
        hold(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            i_data = b81[i];
            hold(BIT_CLK);
        end
        i_data = b81[4];
        hold(BIT_CLK / 2);
        i_rst  = 1'b1;
        i_data = 1'b1;
        hold(1);
        i_rst = 1'b0;
        check("midrst_data_cleared", 32'(o_data), 32'h00);
        hold(3 * BIT_CLK);
        check("midrst_no_strobe", 32'((rx_cnt - base_rx) + (ferr_cnt - base_ferr) + (perr_cnt - base_perr)), 32'd0);
        send_frame(8'h42, 1'b1, BIT_CLK);
        check("after_rst_cnt", 32'(rx_cnt - base_rx), 32'd1);
        check("after_rst_data", 32'(o_data), 32'h42);
        hold(BIT_CLK);

`ifdef UART_RX_PARITY_EN
        mark();
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, BIT_CLK);
        check("par_good_cnt", 32'(rx_cnt - base_rx), 32'd1);
        check("par_good_data", 32'(o_data), 32'h07);
        hold(BIT_CLK);
        mark();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, BIT_CLK);
        hold(BIT_CLK);
        par_flip = 1'b0;
        check("par_bad_perr", 32'(perr_cnt - base_perr), 32'd1);
        check("par_bad_no_rxdone", 32'(rx_cnt - base_rx), 32'd0);
        check("par_bad_data_kept", 32'(o_data), 32'h07);
`else
        check("parity_err_never", 32'(perr_cnt), 32'd0);
`endif

        check("strobe_overlap", 32'(overlap_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
